// File: rtl/tl_mem_responder_pkg.sv
// Shared TileLink-UL constants, FSM encoding and byte-lane helper for the memory responder.
package tl_mem_responder_pkg;

  localparam logic [2:0] TL_PUTFULL       = 3'd0;
  localparam logic [2:0] TL_PUTPARTIAL    = 3'd1;
  localparam logic [2:0] TL_GET           = 3'd4;
  localparam logic [2:0] TL_ACCESSACK     = 3'd0;
  localparam logic [2:0] TL_ACCESSACKDATA = 3'd1;

  localparam logic [3:0] TL_SIZE_WORD = 4'd2;
  localparam logic [3:0] TL_SIZE_LINE = 4'd4;

  typedef enum logic [2:0] {
    IDLE,
    WR_COLLECT,
    RD_FETCH,
    RD_RESP,
    WR_RESP
  } state_t;

  // PutFull always writes every lane; only PutPartial honours the mask.
  function automatic logic [3:0] put_lanes(input logic [2:0] op, input logic [3:0] mask);
    return (op == TL_PUTFULL) ? 4'hf : mask;
  endfunction

endpackage

// File: rtl/tl_mem_responder_ram.sv
// Word RAM, one write port with byte enables and one registered read port; contents never reset.
module tl_mem_responder_ram #(
  parameter int Depth = 1024,
  parameter int Aw    = $clog2(Depth)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [Aw-1:0] wr_idx,
  input  logic [3:0]    wr_be,
  input  logic [31:0]   wr_dat,
  input  logic          rd_en,
  input  logic [Aw-1:0] rd_idx,
  output logic [31:0]   rd_dat
);

  logic [31:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_dat[8*i +: 8];
      end
    end
    if (rd_en) rd_dat <= mem[rd_idx];
  end

endmodule

// File: rtl/tl_mem_responder.sv
// TileLink-UL memory responder: Get/PutFull/PutPartial, word or 4-beat line, one transaction in flight.
// First read beat 2 cycles after the A fire (one fetch bubble per beat); D outputs held while Bus_dBitsReady=0.
module tl_mem_responder
  import tl_mem_responder_pkg::*;
#(
  parameter int          Mem_depth = 1024,
  parameter logic [31:0] Base_addr = 32'h0000_0000,
  parameter logic [1:0]  Sink_id   = 2'b00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Bus_aBitsValid,
  output logic        Bus_aBitsReady,
  input  logic [2:0]  Bus_aBitsOpcode,
  input  logic [2:0]  Bus_aBitsParam,
  input  logic [3:0]  Bus_aBitsSize,
  input  logic [4:0]  Bus_aBitsSource,
  input  logic [31:0] Bus_aBitsAddress,
  input  logic [3:0]  Bus_aBitsMask,
  input  logic [31:0] Bus_aBitsData,
  input  logic        Bus_aBitsCorrupt,
  output logic        Bus_dBitsValid,
  input  logic        Bus_dBitsReady,
  output logic [2:0]  Bus_dBitsOpcode,
  output logic [1:0]  Bus_dBitsParam,
  output logic [3:0]  Bus_dBitsSize,
  output logic [4:0]  Bus_dBitsSource,
  output logic [1:0]  Bus_dBitsSink,
  output logic        Bus_dBitsDennied,
  output logic        Bus_dBitsCorrupt,
  output logic [31:0] Bus_dBitsData
);

  localparam int          Aw      = $clog2(Mem_depth);
  localparam logic [31:0] Depth_w = 32'(Mem_depth);

  state_t state, state_nxt;

  logic [2:0]    op_q;
  logic [3:0]    size_q;
  logic [4:0]    src_q;
  logic          den_q;
  logic          line_q;
  logic [Aw-1:0] idx_q;
  logic [1:0]    cnt_q;

  logic          a_fire, last_beat;
  logic          hdr_op_ok, hdr_size_ok, hdr_line, hdr_get, hdr_den;
  logic [31:0]   hdr_aligned, hdr_off, hdr_last;
  logic [Aw-1:0] hdr_idx, beat_idx;

  logic          wr_en, rd_en;
  logic [Aw-1:0] wr_idx;
  logic [3:0]    wr_be;
  logic [31:0]   rd_dat;

  // Header decode; the whole line range is checked here so no beat can wrap past the top.
  always_comb begin
    hdr_op_ok   = (Bus_aBitsOpcode == TL_PUTFULL) || (Bus_aBitsOpcode == TL_PUTPARTIAL) ||
                  (Bus_aBitsOpcode == TL_GET);
    hdr_size_ok = (Bus_aBitsSize == TL_SIZE_WORD) || (Bus_aBitsSize == TL_SIZE_LINE);
    hdr_line    = (Bus_aBitsSize == TL_SIZE_LINE) && hdr_op_ok;
    hdr_get     = (Bus_aBitsOpcode == TL_GET);
    hdr_aligned = hdr_line ? {Bus_aBitsAddress[31:4], 4'b0000} : {Bus_aBitsAddress[31:2], 2'b00};
    hdr_off     = hdr_aligned - Base_addr;
    hdr_last    = {2'b00, hdr_off[31:2]} + (hdr_line ? 32'd3 : 32'd0);
    hdr_idx     = hdr_off[Aw+1:2];
    hdr_den     = !hdr_op_ok || !hdr_size_ok || (hdr_aligned < Base_addr) ||
                  (hdr_last >= Depth_w) ||
                  ((Bus_aBitsOpcode == TL_PUTPARTIAL) && (Bus_aBitsSize == TL_SIZE_LINE));
  end

  assign a_fire    = Bus_aBitsValid && Bus_aBitsReady;
  assign last_beat = !line_q || (cnt_q == 2'd3);
  assign beat_idx  = idx_q + Aw'(cnt_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (a_fire) state_nxt = hdr_get ? RD_FETCH : (hdr_line ? WR_COLLECT : WR_RESP);
      WR_COLLECT: if (a_fire && (cnt_q == 2'd3)) state_nxt = WR_RESP;
      RD_FETCH:   state_nxt = RD_RESP;
      RD_RESP:    if (Bus_dBitsReady) state_nxt = last_beat ? IDLE : RD_FETCH;
      WR_RESP:    if (Bus_dBitsReady) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    Bus_aBitsReady   = 1'b0;
    Bus_dBitsValid   = 1'b0;
    Bus_dBitsOpcode  = 3'd0;
    Bus_dBitsSize    = 4'd0;
    Bus_dBitsSource  = 5'd0;
    Bus_dBitsSink    = 2'b00;
    Bus_dBitsDennied = 1'b0;
    Bus_dBitsData    = 32'd0;
    case (state)
      IDLE, WR_COLLECT: Bus_aBitsReady = !rst;
      RD_RESP: begin
        Bus_dBitsValid   = 1'b1;
        Bus_dBitsOpcode  = TL_ACCESSACKDATA;
        Bus_dBitsSize    = size_q;
        Bus_dBitsSource  = src_q;
        Bus_dBitsSink    = Sink_id;
        Bus_dBitsDennied = den_q;
        Bus_dBitsData    = den_q ? 32'd0 : rd_dat;
      end
      WR_RESP: begin
        Bus_dBitsValid   = 1'b1;
        Bus_dBitsOpcode  = TL_ACCESSACK;
        Bus_dBitsSize    = size_q;
        Bus_dBitsSource  = src_q;
        Bus_dBitsSink    = Sink_id;
        Bus_dBitsDennied = den_q;
      end
      default: ;
    endcase
  end

  assign Bus_dBitsParam   = 2'b00;
  assign Bus_dBitsCorrupt = 1'b0;

  // A put's first beat is written at header time, so the counter resumes at 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= 3'd0;
      size_q <= 4'd0;
      src_q  <= 5'd0;
      den_q  <= 1'b0;
      line_q <= 1'b0;
      idx_q  <= '0;
      cnt_q  <= 2'd0;
    end else if (state == IDLE && a_fire) begin
      op_q   <= Bus_aBitsOpcode;
      size_q <= Bus_aBitsSize;
      src_q  <= Bus_aBitsSource;
      den_q  <= hdr_den;
      line_q <= hdr_line;
      idx_q  <= hdr_idx;
      cnt_q  <= hdr_get ? 2'd0 : 2'd1;
    end else if ((state == WR_COLLECT && a_fire) ||
                 (state == RD_RESP && Bus_dBitsReady && !last_beat)) begin
      cnt_q <= cnt_q + 2'd1;
    end
  end

  always_comb begin
    wr_en  = 1'b0;
    wr_idx = beat_idx;
    wr_be  = put_lanes(op_q, Bus_aBitsMask);
    if (state == IDLE) begin
      wr_en  = a_fire && !hdr_get && !hdr_den;
      wr_idx = hdr_idx;
      wr_be  = put_lanes(Bus_aBitsOpcode, Bus_aBitsMask);
    end else if (state == WR_COLLECT) begin
      wr_en  = a_fire && !den_q;
    end
  end

  assign rd_en = (state == RD_FETCH);

  tl_mem_responder_ram #(.Depth(Mem_depth), .Aw(Aw)) u_ram (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_idx (wr_idx),
    .wr_be  (wr_be),
    .wr_dat (Bus_aBitsData),
    .rd_en  (rd_en),
    .rd_idx (beat_idx),
    .rd_dat (rd_dat)
  );

  logic unused_ok;
  assign unused_ok = ^{Bus_aBitsParam, Bus_aBitsCorrupt, Bus_aBitsAddress[1:0], hdr_off[1:0]};

endmodule
